// File: rtl/priv_wfi_ctrl.sv
// priv_wfi_ctrl: WFI sequencer. Holds the pipeline while waiting for an
// interrupt, a flush, or a programmable timeout. A timeout produces a
// one-cycle pulse that is folded into the illegal-instruction fault.
module priv_wfi_ctrl #(
    parameter int TIMEOUT_W   = 16,
    parameter int NUM_IRQ     = 12,
    parameter int S_SUPPORTED = 1,
    parameter int U_SUPPORTED = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 StallM,
    input  logic                 FlushM,
    input  logic                 WfiM,
    input  logic [1:0]           PrivilegeModeW,
    input  logic                 STATUS_TW,
    input  logic [TIMEOUT_W-1:0] TimeoutLimit,
    input  logic [NUM_IRQ-1:0]   PendingIntsM,
    output logic                 WFIStallM,
    output logic                 WFIWakeM,
    output logic                 WFITimeoutM,
    output logic [TIMEOUT_W-1:0] WFICountM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TRAP = 2'd2
    } state_e;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] count_q, count_d;
    logic                 toapp_q, toapp_d;
    logic                 wake_q,  wake_d;

    logic irq_pending;
    logic toapp_now;
    logic cnt_sat;
    logic to_hit;

    assign irq_pending = |PendingIntsM;
    assign cnt_sat     = (count_q == CNT_MAX);

    // Timeout applicability as seen at acceptance; without U-mode it never applies.
    assign toapp_now = (U_SUPPORTED != 0) &&
                       ((STATUS_TW && (PrivilegeModeW != 2'b11)) ||
                        ((S_SUPPORTED != 0) && (PrivilegeModeW == 2'b00)));

    // Limit is sampled live. If it is lowered under the running count the
    // equality is missed, so a saturated count also fires the timeout.
    assign to_hit = toapp_q &&
                    ((count_q == (TimeoutLimit - TIMEOUT_W'(1))) || cnt_sat);

    // State register, wait counter, latched applicability and wake pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            toapp_q <= 1'b0;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            toapp_q <= toapp_d;
            wake_q  <= wake_d;
        end
    end

    // Next-state logic: acceptance in IDLE, priority-ordered exits from WAIT.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        toapp_d = toapp_q;
        wake_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (WfiM && !StallM) begin
                    toapp_d = toapp_now;
                    count_d = '0;
                    if (irq_pending) begin
                        wake_d = 1'b1;
                    end else if (toapp_now && (TimeoutLimit == '0)) begin
                        state_d = TRAP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (FlushM) begin
                    state_d = IDLE;
                end else if (irq_pending) begin
                    state_d = IDLE;
                    wake_d  = 1'b1;
                end else if (to_hit) begin
                    state_d = TRAP;
                end else if (!cnt_sat) begin
                    count_d = count_q + TIMEOUT_W'(1);
                end
            end
            TRAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign WFIStallM   = (state_q == WAIT);
    assign WFITimeoutM = (state_q == TRAP);
    assign WFIWakeM    = wake_q;
    assign WFICountM   = count_q;

endmodule

// File: tb/tb_priv_wfi_ctrl.sv
// Directed bench for priv_wfi_ctrl: a 16-bit counter instance for the main
// scenarios and a 4-bit instance for counter saturation, sharing stimulus.
module tb_priv_wfi_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        StallM = 1'b0;
    logic        FlushM = 1'b0;
    logic        WfiM = 1'b0;
    logic [1:0]  PrivilegeModeW = 2'b11;
    logic        STATUS_TW = 1'b0;
    logic [15:0] TimeoutLimit = '0;
    logic [11:0] PendingIntsM = '0;

    logic        stall, wake, tmo;
    logic [15:0] cnt;
    logic        stall4, wake4, tmo4;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    priv_wfi_ctrl #(.TIMEOUT_W(16), .NUM_IRQ(12), .S_SUPPORTED(1), .U_SUPPORTED(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .StallM(StallM), .FlushM(FlushM), .WfiM(WfiM),
        .PrivilegeModeW(PrivilegeModeW), .STATUS_TW(STATUS_TW), .TimeoutLimit(TimeoutLimit),
        .PendingIntsM(PendingIntsM), .WFIStallM(stall), .WFIWakeM(wake),
        .WFITimeoutM(tmo), .WFICountM(cnt)
    );

    priv_wfi_ctrl #(.TIMEOUT_W(4), .NUM_IRQ(12), .S_SUPPORTED(1), .U_SUPPORTED(1)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .StallM(StallM), .FlushM(FlushM), .WfiM(WfiM),
        .PrivilegeModeW(PrivilegeModeW), .STATUS_TW(STATUS_TW), .TimeoutLimit(TimeoutLimit[3:0]),
        .PendingIntsM(PendingIntsM), .WFIStallM(stall4), .WFIWakeM(wake4),
        .WFITimeoutM(tmo4), .WFICountM(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wake",  32'(wake),  0);
        chk("rst_tmo",   32'(tmo),   0);
        chk("rst_cnt",   32'(cnt),   0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // U-mode, L=4: stall 4 cycles counting 0..3, then one timeout pulse
        PrivilegeModeW = 2'b00; STATUS_TW = 1'b0; TimeoutLimit = 16'd4;
        WfiM = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            WfiM = 1'b0;
            chk("u_stall", 32'(stall), 1);
            chk("u_cnt",   32'(cnt),   32'(k));
            chk("u_tmo_early", 32'(tmo), 0);
        end
        tick();
        chk("u_tmo",       32'(tmo),   1);
        chk("u_stall_end", 32'(stall), 0);
        chk("u_wake_none", 32'(wake),  0);
        tick();
        chk("u_tmo_once",  32'(tmo),   0);

        // M-mode, TW=1, L=3: no timeout, wake after 20 stalled cycles
        PrivilegeModeW = 2'b11; STATUS_TW = 1'b1; TimeoutLimit = 16'd3;
        WfiM = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            WfiM = 1'b0;
            chk("m_stall", 32'(stall), 1);
            chk("m_tmo",   32'(tmo),   0);
        end
        PendingIntsM = 12'h080;
        tick();
        chk("m_wake",       32'(wake),  1);
        chk("m_stall_drop", 32'(stall), 0);
        PendingIntsM = '0;
        tick();
        chk("m_wake_once",  32'(wake),  0);

        // S-mode, TW=1, L=5: interrupt coincides with count==4, wake wins
        PrivilegeModeW = 2'b01; STATUS_TW = 1'b1; TimeoutLimit = 16'd5;
        WfiM = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            WfiM = 1'b0;
            chk("s_cnt", 32'(cnt), 32'(k));
        end
        PendingIntsM = 12'h001;
        tick();
        chk("s_wake",  32'(wake), 1);
        chk("s_notmo", 32'(tmo),  0);
        PendingIntsM = '0;
        tick();
        chk("s_notmo2", 32'(tmo),   0);
        chk("s_idle",   32'(stall), 0);

        // Interrupt pending at acceptance: immediate wake, no stall
        PrivilegeModeW = 2'b00; STATUS_TW = 1'b0; TimeoutLimit = 16'd4;
        PendingIntsM = 12'h001; WfiM = 1'b1;
        tick();
        chk("pa_wake",  32'(wake),  1);
        chk("pa_stall", 32'(stall), 0);
        WfiM = 1'b0; PendingIntsM = '0;
        tick();
        chk("pa_stall2", 32'(stall), 0);
        chk("pa_wake2",  32'(wake),  0);

        // StallM blocks acceptance
        StallM = 1'b1; WfiM = 1'b1;
        tick();
        chk("stl_noacc", 32'(stall), 0);
        StallM = 1'b0; WfiM = 1'b0;
        tick();

        // L=0 with timeout applicable: immediate trap, no stall
        TimeoutLimit = 16'd0; WfiM = 1'b1;
        tick();
        WfiM = 1'b0;
        chk("l0_tmo",   32'(tmo),   1);
        chk("l0_stall", 32'(stall), 0);
        tick();
        chk("l0_tmo_once", 32'(tmo), 0);

        // 4-bit counter saturation with timeout not applicable
        do_reset();
        PrivilegeModeW = 2'b11; STATUS_TW = 1'b0; TimeoutLimit = 16'd0;
        WfiM = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            WfiM = 1'b0;
            if (i == 1 || i == 16 || i == 17 || i == 40) begin
                chk("sat_cnt4",   32'(cnt4),   (i - 1 > 15) ? 32'd15 : 32'(i - 1));
                chk("sat_stall4", 32'(stall4), 1);
            end
        end
        chk("sat_cnt16", 32'(cnt), 32'd39);
        chk("sat_tmo4",  32'(tmo4), 0);
        PendingIntsM = 12'h800;
        tick();
        chk("sat_wake4",  32'(wake4),  1);
        chk("sat_stall4_end", 32'(stall4), 0);
        chk("sat_hold4",  32'(cnt4),   15);
        PendingIntsM = '0;
        tick();

        // Flush during WAIT beats a simultaneous interrupt
        PrivilegeModeW = 2'b00; TimeoutLimit = 16'd10;
        WfiM = 1'b1;
        tick();
        WfiM = 1'b0;
        tick();
        chk("fl_stall", 32'(stall), 1);
        FlushM = 1'b1; PendingIntsM = 12'h004;
        tick();
        FlushM = 1'b0; PendingIntsM = '0;
        chk("fl_idle",  32'(stall), 0);
        chk("fl_nowake", 32'(wake), 0);
        chk("fl_notmo",  32'(tmo),  0);
        tick();
        chk("fl_nowake2", 32'(wake), 0);

        // Asynchronous reset mid-WAIT
        WfiM = 1'b1;
        tick();
        WfiM = 1'b0;
        tick();
        chk("ar_stall", 32'(stall), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_drop",  32'(stall), 0);
        chk("ar_cnt",   32'(cnt),   0);
        tick();
        chk("ar_nowake", 32'(wake), 0);
        chk("ar_notmo",  32'(tmo),  0);
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priv_wfi_ctrl.md
# priv_wfi_ctrl

Parametrised WFI sequencer for the privileged unit: takes the decoded `wfi` from the Memory stage and holds the pipeline until an interrupt becomes pending, a flush arrives, or a runtime-programmable timeout expires. On timeout it raises an illegal-instruction pulse for trap handling. It adds three capabilities over a free-running fixed-bit WFI counter: a real wait state with pipeline stall, interrupt wake-up, and a configurable timeout width and limit. It sits beside the privileged decoder; its `WFITimeoutM` is ORed into `IllegalInstrFaultM`.

## Interface
- `TIMEOUT_W`, 16: counter and limit width in bits.
- `NUM_IRQ`, 12: number of pending-interrupt lines.
- `S_SUPPORTED`, 1: supervisor mode present; enables the U-mode timeout rule.
- `U_SUPPORTED`, 1: user mode present; if 0, the timeout is never applicable.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `StallM`  in  1  Memory stage stalled; a `WfiM` is accepted only when this is 0.
- `FlushM`  in  1  aborts a wait in progress.
- `WfiM`  in  1  decoded, privilege-legal `wfi` in the Memory stage.
- `PrivilegeModeW`  in  2  current mode: M=2'b11, S=2'b01, U=2'b00.
- `STATUS_TW`  in  1  mstatus.TW.
- `TimeoutLimit`  in  TIMEOUT_W  timeout in wait cycles.
- `PendingIntsM`  in  NUM_IRQ  pending interrupts (mip & mie), taken regardless of global enable.
- `WFIStallM`  out  1  stalls the pipeline while waiting.
- `WFIWakeM`  out  1  one-cycle pulse: WFI retires normally.
- `WFITimeoutM`  out  1  one-cycle pulse: illegal-instruction trap.
- `WFICountM`  out  TIMEOUT_W  current wait count.

## Operation
- States: IDLE, WAIT, TRAP. All outputs are registered or decoded from state and count.
- Timeout applicability (`TOapp`) is computed and latched at acceptance: (`STATUS_TW` & mode≠M) | (`S_SUPPORTED` & mode==U). It is forced to 0 when `U_SUPPORTED`=0. Changes to mode or TW during WAIT are ignored.
- IDLE, acceptance (`WfiM` & ~`StallM`):
  - If `|PendingIntsM` → stay in IDLE and pulse `WFIWakeM` next cycle. No stall.
  - Else if `TOapp` & `TimeoutLimit`==0 → TRAP.
  - Else → WAIT with count cleared to 0.
- WAIT, evaluated in priority order:
  1. `FlushM` → IDLE. No pulse.
  2. `|PendingIntsM` → IDLE with `WFIWakeM` pulse.
  3. `TOapp` & count==`TimeoutLimit`−1 → TRAP.
  4. Otherwise count+1. The count saturates at all-ones and never wraps, so a non-timeout wait is unbounded.
- TRAP: `WFITimeoutM`=1 for exactly one cycle, then IDLE unconditionally.
- `TimeoutLimit` is sampled live each WAIT cycle. If it is lowered below the current count+1, the timeout does not fire until the count saturates. Software must not change it during a wait.
- `WfiM` is ignored in WAIT and TRAP.
- `WFIStallM` = (state==WAIT).
- `WFICountM` holds its value in IDLE and TRAP and is cleared on the next acceptance.

## Timing
- Reset: state IDLE, count 0, and all outputs 0, asynchronously on `reset_n` low. Reset during WAIT drops `WFIStallM` immediately and produces no pulse.
- Acceptance in cycle N, no pending interrupt, timeout applicable, L=`TimeoutLimit`≥1:
  - `WFIStallM`=1 in cycles N+1..N+L, with `WFICountM`=k in cycle N+1+k.
  - `WFITimeoutM`=1 in cycle N+L+1.
  - IDLE from N+L+2.
- L=0 with timeout applicable: `WFITimeoutM` in N+1 and no stall.
- Interrupt sampled in WAIT cycle C: `WFIWakeM`=1 and `WFIStallM`=0 in C+1.
- Interrupt already pending at acceptance: `WFIWakeM` in N+1.
- Interrupt and timeout condition in the same cycle: the wake wins and no trap occurs.
- `FlushM` in cycle C of WAIT: IDLE in C+1, no pulses. Flush beats interrupt.
- At most one of `WFIWakeM` and `WFITimeoutM` is asserted in any cycle.

## Test plan
- Reset, then U-mode, `S_SUPPORTED`=1, L=4, no interrupts, `WfiM` at cycle 10:
  - `WFIStallM` high in cycles 11–14, with `WFICountM` 0..3.
  - `WFITimeoutM` high in cycle 15 only.
- M-mode, TW=1, L=3, interrupt bit 7 raised at cycle 30 after acceptance at 10:
  - No trap.
  - `WFIStallM` high in cycles 11–30.
  - `WFIWakeM` in cycle 31.
- S-mode, TW=1, L=5, interrupt and count==4 in the same cycle: `WFIWakeM`=1, `WFITimeoutM`=0.
- `PendingIntsM`=1 at acceptance: `WFIWakeM` next cycle and `WFIStallM` never asserts. Separately, L=0 with timeout applicable: `WFITimeoutM` next cycle.
- `TIMEOUT_W`=4, M-mode with timeout not applicable, 40-cycle wait:
  - `WFICountM` saturates at 15.
  - Interrupt at cycle 40 gives a wake.
- `FlushM` in WAIT: no pulses, IDLE next cycle. `reset_n` low mid-WAIT: `WFIStallM` low in the same cycle.
